// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences PC, IR, ALU and register file,
// handshakes with memory and parks in HALTED on halt, bad opcode or timeout.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 256,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero_flag,
   input  logic       mem_ready,
   input  logic       pc_halt,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       halted,
   output logic [1:0] err_code
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE,
      EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, HALTED
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       err;
   logic             waiting;
   logic             tmo;
   logic             unused_zero;

   // zero_flag goes straight to the PC; the FSM never looks at it
   assign unused_zero = zero_flag;

   assign waiting = (state == FETCH || state == MEMREAD || state == MEMWRITE)
                    && !mem_ready;
   assign tmo     = (MEM_TIMEOUT != 0) && waiting && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FETCH;
         cnt   <= '0;
         err   <= 2'b00;
      end else if (state != HALTED) begin
         if (pc_halt) begin
            state <= HALTED;
            err   <= 2'b01;
            cnt   <= '0;
         end else if (tmo) begin
            state <= HALTED;
            err   <= 2'b11;
            cnt   <= '0;
         end else begin
            cnt <= waiting ? cnt + 1'b1 : '0;
            unique case (state)
               FETCH:    if (mem_ready) state <= DECODE;
               DECODE: begin
                  case (opcode)
                     6'h00:        state <= EXEC_R;
                     6'h23, 6'h2B: state <= MEMADDR;
                     6'h04:        state <= BRANCH;
                     6'h02:        state <= JUMP;
                     6'h08:        state <= EXEC_I;
                     default: begin
                        state <= HALTED;
                        err   <= 2'b10;
                     end
                  endcase
               end
               MEMADDR:  state <= (opcode == 6'h23) ? MEMREAD : MEMWRITE;
               MEMREAD:  if (mem_ready) state <= MEMWB;
               MEMWRITE: if (mem_ready) state <= FETCH;
               EXEC_R:   state <= RWB;
               EXEC_I:   state <= IWB;
               MEMWB, RWB, IWB, BRANCH, JUMP: state <= FETCH;
               default:  state <= HALTED;
            endcase
         end
      end
   end

   assign err_code = err;

   always_comb begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      halted        = 1'b0;
      if (rst) begin
         unique case (state)
            FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            DECODE:   alu_src_b = 2'b11;
            MEMADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            MEMREAD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
            end
            EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
            end
            RWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            IWB:      reg_write = 1'b1;
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = 2'b01;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
            end
            HALTED:   halted = 1'b1;
            default:  halted = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-cycle expected control words built
// from instruction class and randomized memory wait counts.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       zero_flag;
   logic       mem_ready;
   logic       pc_halt;
   logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
   logic [1:0] pc_source, alu_src_b, alu_op, err_code;
   logic       alu_src_a, reg_write, reg_dst, mem_to_reg, halted;
   logic [18:0] obs;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag),
      .mem_ready(mem_ready), .pc_halt(pc_halt), .mem_req(mem_req),
      .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .halted(halted), .err_code(err_code)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                 pc_source, alu_src_a, alu_src_b, alu_op, reg_write,
                 reg_dst, mem_to_reg, halted, err_code};

   function automatic logic [18:0] v(
      input logic req, we, ia, irw, pcw, pcwc,
      input logic [1:0] psrc, input logic asa, input logic [1:0] asb,
      input logic [1:0] aop, input logic rw, rd, m2r, h,
      input logic [1:0] e);
      return {req, we, ia, irw, pcw, pcwc, psrc, asa, asb, aop,
              rw, rd, m2r, h, e};
   endfunction

   // expected control words, one per machine step
   logic [18:0] F_WAIT, F_RDY, DEC, MADDR, MRD, MWB, MWR;
   logic [18:0] EXR, RWBV, EXI, IWBV, BR, JMP;

   function automatic logic [18:0] halt_v(input logic [1:0] e);
      return v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,1,e);
   endfunction

   task automatic chk(input logic [18:0] e, input string tag);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   // called just after a rising edge; checks mid-cycle, returns after next edge
   task automatic cyc(input logic rdy, input logic [18:0] e, input string tag);
      mem_ready = rdy;
      zero_flag = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk(e, tag);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int w);
      for (int k = 0; k < w; k++) cyc(1'b0, F_WAIT, "fetch_wait");
      cyc(1'b1, F_RDY, "fetch_rdy");
   endtask

   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      opcode = op;
      fetch(wf);
      cyc(1'($urandom_range(0, 1)), DEC, "decode");
      case (op)
         6'h00: begin
            cyc(1'($urandom_range(0, 1)), EXR, "exec_r");
            cyc(1'($urandom_range(0, 1)), RWBV, "r_wb");
         end
         6'h08: begin
            cyc(1'($urandom_range(0, 1)), EXI, "exec_i");
            cyc(1'($urandom_range(0, 1)), IWBV, "i_wb");
         end
         6'h04: cyc(1'($urandom_range(0, 1)), BR, "branch");
         6'h02: cyc(1'($urandom_range(0, 1)), JMP, "jump");
         6'h23: begin
            cyc(1'($urandom_range(0, 1)), MADDR, "lw_addr");
            for (int k = 0; k < wm; k++) cyc(1'b0, MRD, "lw_wait");
            cyc(1'b1, MRD, "lw_rdy");
            cyc(1'($urandom_range(0, 1)), MWB, "lw_wb");
         end
         default: begin
            cyc(1'($urandom_range(0, 1)), MADDR, "sw_addr");
            for (int k = 0; k < wm; k++) cyc(1'b0, MWR, "sw_wait");
            cyc(1'b1, MWR, "sw_rdy");
         end
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk('0, "reset_zero");
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   logic [5:0] legal [6];

   initial begin
      F_WAIT = v(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0,2'b00);
      F_RDY  = v(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0,2'b00);
      DEC    = v(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0,2'b00);
      MADDR  = v(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,2'b00);
      MRD    = v(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,2'b00);
      MWB    = v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0,2'b00);
      MWR    = v(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0,2'b00);
      EXR    = v(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0,2'b00);
      RWBV   = v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,0,0,2'b00);
      EXI    = v(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0,2'b00);
      IWBV   = v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,0,0,2'b00);
      BR     = v(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0,2'b00);
      JMP    = v(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,0,2'b00);
      legal  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

      rst = 1'b0;
      opcode = 6'h00;
      zero_flag = 1'b0;
      mem_ready = 1'b1;
      pc_halt = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // R-type with memory always ready
      for (int i = 0; i < 3; i++) run_instr(6'h00, 0, 0);
      // lw with three wait cycles in MEMREAD
      run_instr(6'h23, 0, 3);

      // random program; waits up to 3 stay just under the 4-cycle timeout
      for (int i = 0; i < 60; i++)
         run_instr(legal[$urandom_range(0, 5)],
                   $urandom_range(0, 3), $urandom_range(0, 3));

      // illegal opcode parks with err 10
      opcode = 6'h3F;
      fetch(1);
      cyc(1'b1, DEC, "decode_bad");
      for (int k = 0; k < 4; k++)
         cyc(1'($urandom_range(0, 1)), halt_v(2'b10), "halt_illegal");

      // fetch timeout
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1'b0, F_WAIT, "to_wait");
      for (int k = 0; k < 3; k++)
         cyc(1'($urandom_range(0, 1)), halt_v(2'b11), "halt_timeout");

      // memwrite timeout
      do_reset();
      opcode = 6'h2B;
      fetch(0);
      cyc(1'b0, DEC, "decode_sw");
      cyc(1'b0, MADDR, "sw_addr_to");
      for (int k = 0; k < 4; k++) cyc(1'b0, MWR, "sw_to_wait");
      cyc(1'b1, halt_v(2'b11), "halt_sw_timeout");

      // pc_halt during EXEC_R
      do_reset();
      run_instr(6'h08, 1, 0);
      opcode = 6'h00;
      fetch(2);
      cyc(1'b0, DEC, "decode_r");
      pc_halt = 1'b1;
      cyc(1'b0, EXR, "exec_r_halt");
      pc_halt = 1'b0;
      cyc(1'b1, halt_v(2'b01), "halt_pc");
      cyc(1'b0, halt_v(2'b01), "halt_pc_hold");

      // pc_halt coinciding with mem_ready in FETCH
      do_reset();
      pc_halt = 1'b1;
      cyc(1'b1, F_RDY, "fetch_rdy_halt");
      pc_halt = 1'b0;
      cyc(1'b1, halt_v(2'b01), "halt_after_fetch");

      // reset mid-MEMWRITE
      do_reset();
      opcode = 6'h2B;
      fetch(0);
      cyc(1'b0, DEC, "decode_sw2");
      cyc(1'b0, MADDR, "sw_addr2");
      cyc(1'b0, MWR, "sw_wait2");
      mem_ready = 1'b0;
      rst = 1'b0;
      #1;
      chk('0, "rst_mid_write");
      @(negedge clk);
      chk('0, "rst_mid_write_hold");
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_instr(6'h04, 0, 0);
      run_instr(6'h02, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
